// File: rtl/ssd_pkg.sv
// Shared types and segment tables for the seven-segment scan driver.
package ssd_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low {g,f,e,d,c,b,a} for decimal digits 0..9
    localparam logic [6:0] seg7 [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] nibble);
        logic [6:0] seg;
        seg = SEG_BLANK;
        if (nibble <= 4'd9) begin
            seg = seg7[nibble];
        end
        return seg;
    endfunction

endpackage

// File: rtl/ssd_scan_driver_if.sv
// Load/result bus between the CPU debug mux and the display driver.
interface ssd_scan_driver_if #(
    parameter int unsigned IN_W   = 13,
    parameter int unsigned DIGITS = 4
);

    logic [IN_W-1:0]     value_in;
    logic                load;
    logic                busy;
    logic [4*DIGITS-1:0] bcd_out;

    modport master (
        output value_in,
        output load,
        input  busy,
        input  bcd_out
    );

    modport slave (
        input  value_in,
        input  load,
        output busy,
        output bcd_out
    );

endinterface

// File: rtl/bcd_dabble_seq.sv
// Sequential double-dabble binary-to-BCD converter with a one-deep pending load.
module bcd_dabble_seq
    import ssd_pkg::*;
#(
    parameter int unsigned IN_W   = 13,
    parameter int unsigned DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IN_W-1:0]     value_in,
    input  logic                load,
    output logic                busy,
    output logic [4*DIGITS-1:0] bcd_out
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(IN_W + 1);

    state_t           state_q, state_d;
    logic [IN_W-1:0]  bin_q, bin_d;
    logic [BCD_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic [IN_W-1:0]  pend_val_q, pend_val_d;
    logic [BCD_W-1:0] bcd_out_q, bcd_out_d;
    logic [BCD_W-1:0] adj;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            bin_q      <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            pend_q     <= 1'b0;
            pend_val_q <= '0;
            bcd_out_q  <= '0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            pend_val_q <= pend_val_d;
            bcd_out_q  <= bcd_out_d;
        end
    end

    always_comb begin
        adj = acc_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        bcd_out_d  = bcd_out_q;

        case (state_q)
            StIdle: begin
                if (load) begin
                    bin_d   = value_in;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                acc_d = {adj[BCD_W-2:0], bin_q[IN_W-1]};
                bin_d = bin_q << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(IN_W - 1)) begin
                    state_d = StDone;
                end
                if (load) begin
                    pend_d     = 1'b1;
                    pend_val_d = value_in;
                end
            end
            StDone: begin
                bcd_out_d = acc_q;
                acc_d     = '0;
                cnt_d     = '0;
                if (pend_q) begin
                    bin_d   = pend_val_q;
                    pend_d  = 1'b0;
                    state_d = StShift;
                    // A load landing on the reload cycle becomes the next pending value
                    if (load) begin
                        pend_d     = 1'b1;
                        pend_val_d = value_in;
                    end
                end else if (load) begin
                    bin_d   = value_in;
                    state_d = StShift;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy    = (state_q != StIdle) | pend_q;
    assign bcd_out = bcd_out_q;

endmodule

// File: rtl/ssd_scan_driver.sv
// BCD conversion plus multiplexed common-anode display scan.
// Define SSD_LZB_EN to blank leading zero digits (digit 0 is never blanked).
module ssd_scan_driver
    import ssd_pkg::*;
#(
    parameter int unsigned IN_W         = 13,
    parameter int unsigned DIGITS       = 4,
    parameter int unsigned REFRESH_BITS = 18
) (
    input  logic              clk,
    input  logic              rst,
    ssd_scan_driver_if.slave  bus,
    output logic [DIGITS-1:0] anode,
    output logic [6:0]        cathode
);

    localparam int unsigned SEL_W = $clog2(DIGITS);

    logic [REFRESH_BITS-1:0] refresh_q;
    logic [DIGITS-1:0]       anode_q, anode_d;
    logic [6:0]              cathode_q, cathode_d;
    logic [4*DIGITS-1:0]     bcd;
    logic [SEL_W-1:0]        sel;
    logic [3:0]              digit;
    logic                    blank;

    bcd_dabble_seq #(
        .IN_W   (IN_W),
        .DIGITS (DIGITS)
    ) u_dabble (
        .clk      (clk),
        .rst      (rst),
        .value_in (bus.value_in),
        .load     (bus.load),
        .busy     (bus.busy),
        .bcd_out  (bcd)
    );

    assign bus.bcd_out = bcd;
    assign sel         = refresh_q[REFRESH_BITS-1 -: SEL_W];
    assign digit       = bcd[4*sel +: 4];

`ifdef SSD_LZB_EN
    logic [DIGITS-1:0] lead_zero;
    logic              above_zero;

    // lead_zero[i] set when digit i and every digit above it are zero
    always_comb begin
        lead_zero  = '0;
        above_zero = 1'b1;
        for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            above_zero   = above_zero & (bcd[4*i +: 4] == 4'd0);
            lead_zero[i] = above_zero;
        end
    end

    assign blank = lead_zero[sel];
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        anode_d   = ~(DIGITS'(1) << sel);
        cathode_d = blank ? SEG_BLANK : bcd_to_seg(digit);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            refresh_q <= '0;
            anode_q   <= '1;
            cathode_q <= SEG_BLANK;
        end else begin
            refresh_q <= refresh_q + 1'b1;
            anode_q   <= anode_d;
            cathode_q <= cathode_d;
        end
    end

    assign anode   = anode_q;
    assign cathode = cathode_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Directed bench for ssd_scan_driver with a short refresh counter.
module tb_ssd_scan_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] anode;
    logic [6:0] cathode;
    int         checks = 0;
    int         errors = 0;

    ssd_scan_driver_if #(.IN_W(13), .DIGITS(4)) bus ();

    ssd_scan_driver #(
        .IN_W         (13),
        .DIGITS       (4),
        .REFRESH_BITS (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .anode   (anode),
        .cathode (cathode)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] C0 = 7'b1000000;
    localparam logic [6:0] C1 = 7'b1111001;
    localparam logic [6:0] C2 = 7'b0100100;
    localparam logic [6:0] C3 = 7'b0110000;
    localparam logic [6:0] C4 = 7'b0011001;
    localparam logic [6:0] C7 = 7'b1111000;
    localparam logic [6:0] CB = 7'b1111111;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic [12:0] v);
        bus.value_in = v;
        bus.load     = 1'b1;
        tick();
        bus.load     = 1'b0;
    endtask

    task automatic run_conv(input logic [12:0] v, input logic [15:0] exp);
        int n;
        start_load(v);
        n = 0;
        while (bus.busy && n < 100) begin
            n++;
            tick();
        end
        check($sformatf("busy_cycles_%0d", v), n, 14);
        check($sformatf("bcd_%0d", v), bus.bcd_out, exp);
    endtask

    // Sync to the start of digit 1, then check each digit's first displayed cycle
    task automatic check_scan(input logic [6:0] c0, input logic [6:0] c1,
                              input logic [6:0] c2, input logic [6:0] c3);
        logic [6:0] exp_c [4];
        logic [3:0] exp_a [4];
        int n;
        exp_c = '{c0, c1, c2, c3};
        exp_a = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        n = 0;
        while (anode !== 4'b1110 && n < 40) begin
            tick();
            n++;
        end
        while (anode === 4'b1110 && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) check("scan_sync_timeout", n, 0);
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("anode_d%0d", k % 4), anode, exp_a[k % 4]);
            check($sformatf("cathode_d%0d", k % 4), cathode, exp_c[k % 4]);
            repeat (4) tick();
        end
    endtask

    initial begin
        int  n;
        bit  seen200;
        bus.load     = 1'b0;
        bus.value_in = '0;

        // Reset state
        repeat (3) tick();
        check("rst_anode", anode, 4'b1111);
        check("rst_cathode", cathode, CB);
        check("rst_bcd", bus.bcd_out, 16'h0000);
        check("rst_busy", bus.busy, 1'b0);
        rst = 1'b1;
        tick();
        check("first_anode", anode, 4'b1110);
        check("first_cathode", cathode, C0);

        // Basic conversion and scan
        run_conv(13'd1234, 16'h1234);
        check_scan(C4, C3, C2, C1);

        // Extremes
        run_conv(13'd8191, 16'h8191);
        run_conv(13'd0, 16'h0000);
`ifdef SSD_LZB_EN
        check_scan(C0, CB, CB, CB);
`else
        check_scan(C0, C0, C0, C0);
`endif

        // Loads while busy: 200 is overwritten by 300
        seen200 = 1'b0;
        start_load(13'd100);
        repeat (4) tick();
        start_load(13'd200);
        start_load(13'd300);
        repeat (7) begin
            tick();
            if (bus.bcd_out == 16'h0200) seen200 = 1'b1;
        end
        check("pend_before_done", bus.bcd_out, 16'h0000);
        check("pend_busy_mid", bus.busy, 1'b1);
        tick();
        check("pend_first", bus.bcd_out, 16'h0100);
        check("pend_busy_reload", bus.busy, 1'b1);
        n = 0;
        while (bus.busy && n < 100) begin
            if (bus.bcd_out == 16'h0200) seen200 = 1'b1;
            n++;
            tick();
        end
        check("pend_busy_cycles", n, 14);
        check("pend_second", bus.bcd_out, 16'h0300);
        check("pend_200_hidden", seen200, 1'b0);

        // Reset in the middle of a conversion
        start_load(13'd4321);
        repeat (5) tick();
        rst = 1'b0;
        #1;
        check("midrst_bcd", bus.bcd_out, 16'h0000);
        check("midrst_busy", bus.busy, 1'b0);
        check("midrst_anode", anode, 4'b1111);
        tick();
        rst = 1'b1;
        repeat (20) tick();
        check("midrst_bcd_after", bus.bcd_out, 16'h0000);
        check("midrst_busy_after", bus.busy, 1'b0);
        run_conv(13'd4321, 16'h4321);

        // Leading-zero behaviour
        run_conv(13'd7, 16'h0007);
`ifdef SSD_LZB_EN
        check_scan(C7, CB, CB, CB);
`else
        check_scan(C7, C0, C0, C0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ssd_scan_driver.md
Name: ssd_scan_driver

Overview:
- Downstream consumer of the CPU top's 13-bit SSD debug value.
- Converts the binary value to 4 BCD digits with a sequential shift-add-3 (double-dabble) converter.
- Time-multiplexes the digits onto a 4-digit common-anode seven-segment display.
- Sits between the CPU debug mux and the board display pins, clocked by the display clock.

Parameters:
- IN_W, 13, binary input width; must satisfy 2^IN_W - 1 <= 9999.
- DIGITS, 4, number of BCD digits and anodes driven.
- REFRESH_BITS, 18, refresh counter width; its top 2 bits select the active digit.

Ports:
- clk  in  1  display clock (the CPU's SSDClk).
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- value_in  in  IN_W  binary value to display.
- load  in  1  single-cycle strobe: sample value_in.
- busy  out  1  conversion in progress or pending.
- bcd_out  out  4*DIGITS  last completed BCD result; digit 0 in [3:0].
- anode  out  DIGITS  digit enables, active-low.
- cathode  out  7  segments {g,f,e,d,c,b,a}, active-low.

Behaviour:
- Reset values (async, rst=0): busy=0, bcd_out=0, anode=4'b1111, cathode=7'b1111111, refresh counter=0, FSM=IDLE, pending=0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - load=1 → latch value_in into the shift register, clear the BCD accumulator and bit counter, go to SHIFT.
  - busy rises in the next cycle.
- SHIFT, one bit per cycle for exactly IN_W cycles:
  - Add 3 to each BCD nibble that is >= 5.
  - Then shift {bcd, bin} left by 1.
  - After IN_W iterations, go to DONE.
- DONE (1 cycle):
  - bcd_out <= accumulator.
  - If pending=1: reload from the pending register, clear pending, go to SHIFT.
  - Else go to IDLE.
- Latency: load at cycle N → bcd_out updated at the clock edge ending cycle N+IN_W+1 (cycle N+14 for defaults).
- busy = (state != IDLE) | pending.
- load while busy:
  - value_in is stored in the pending register (last write wins) and pending is set.
  - The in-flight conversion is never aborted.
- load in the same cycle DONE occurs with pending=0: treated as pending and starts immediately after.
- Refresh counter:
  - Free-running, wraps 2^REFRESH_BITS-1 → 0.
  - sel = counter[REFRESH_BITS-1 -: 2].
  - anode[sel]=0, other anodes 1.
  - cathode = segment pattern of bcd_out digit sel.
  - Outputs are registered: 1-cycle lag after a sel change.
- Scanning continues during conversion and shows the old bcd_out; no tearing.
- Segment codes, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - codes 10–15 = 1111111 (blank).
- Reset mid-conversion: everything returns to reset values immediately; the partial result is discarded.

Optional Feature:
- Macro: SSD_LZB_EN (leading-zero blanking).
- Defined:
  - Any digit above the most significant nonzero digit drives cathode=7'b1111111 while still being scanned (its anode is still enabled).
  - Digit 0 is never blanked, so the value 0 shows a single "0".
- Undefined: all DIGITS digits always display, including leading zeros.

Decomposition:
- Package ssd_pkg:
  - seg7 segment-code constant array for 0–9.
  - SEG_BLANK constant.
  - FSM state typedef (IDLE/SHIFT/DONE).
  - Function bcd_to_seg(nibble).
- One natural sub-module: bcd_dabble_seq, which holds the FSM, shift register, pending logic and bcd_out.
- The top keeps the refresh counter, digit mux and optional blanking.

Test Plan (REFRESH_BITS=4 for simulation, so each digit is shown 4 cycles):
1. Reset check: hold rst=0 for 3 cycles → anode=1111, cathode=1111111, bcd_out=0, busy=0. Release rst → digit 0 scans with cathode=1000000.
2. Basic conversion: load value_in=13'd1234 → busy high for 14 cycles; bcd_out=16'h1234 at N+14. Scan shows anode 1110/1101/1011/0111 with cathodes 0011001, 0110000, 0100100, 1111001.
3. Maximum value: load 8191 → bcd_out=16'h8191. Load 0 → bcd_out=16'h0000.
4. Load while busy: load 100, then 5 cycles later load 200, then load 300 on the next cycle. bcd_out goes 0100 → 0300; 200 is never displayed; busy drops after the second DONE.
5. Reset mid-operation: load 4321 and assert rst at SHIFT iteration 6 → bcd_out stays 0. After release, a fresh load of 4321 yields 16'h4321.
6. Blanking with SSD_LZB_EN: load 7 → digits 3..1 show 1111111 and digit 0 shows 1111000. Without the macro, digits 3..1 show 1000000.
